sobel_window_core: RTL
======================

Name: sobel_window_core

Overview:
Downstream consumer of the 8-bit line-delay buffer in the Sobel edge-detection datapath. Takes the live pixel plus two row-delayed pixels (two chained line delays sharing the same Enable) and builds a 3x3 window. Computes Gx/Gy and the saturated magnitude |Gx|+|Gy|. Emits one 8-bit edge pixel per interior window with a valid strobe.

Parameters:
IMG_WIDTH, 256, pixels per row; must equal the line-delay depth
IMG_HEIGHT, 256, rows per frame
THRESHOLD, 64, binarisation level; used only when SOBEL_THRESHOLD_EN is defined

Ports:
CLK  input  1  single clock, rising-edge
RST_n  input  1  synchronous active-low reset
Enable  input  1  pixel accept strobe; same signal drives the line delays
DataIn  input  8  current pixel, row r, column c
Line1In  input  8  pixel at row r-1, column c (first line-delay output)
Line2In  input  8  pixel at row r-2, column c (second line-delay output)
DataOut  output  8  edge magnitude, or binary 0/255 with the option
ValidOut  output  1  DataOut holds a new result this cycle
EndOfFrame  output  1  high with the ValidOut of the last window in the frame

Behaviour:
- Reset (RST_n=0 at a rising edge): col=0, row=0, window regs=0, all pipeline valids=0. DataOut=0, ValidOut=0, EndOfFrame=0. Reset overrides Enable.
- Accept: a pixel is accepted on an edge with Enable=1. With Enable=0, counters and window hold and no new window enters the pipeline. Stages 2/3 still drain every cycle; there is no backpressure.
- Counters: col increments per accepted pixel and wraps W-1 -> 0 with row++. row wraps H-1 -> 0, giving the next frame with no gap.
- Window: 3 columns x 3 rows. On accept, shift left: column 2 <= {Line2In, Line1In, DataIn}, top to bottom. Column 2 is the newest.
- Stage 1 (accept edge k): win_valid <= Enable && row>=2 && col>=2, using pre-increment counter values.
- Stage 2 (edge k+1):
  - Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20).
  - Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02).
  - Row index first; row 0 is the oldest. 11-bit signed, range ±1020.
- Stage 3 (edge k+2): mag = |Gx| + |Gy| as 12-bit unsigned (≤2040). DataOut = mag>255 ? 255 : mag. ValidOut <= stage-2 valid.
- Latency: result visible after edge k+2, i.e. 2 cycles after the accept edge. Throughput is 1 pixel per clock.
- Windows whose left column is the row wrap are masked by the col>=2 rule. No border output is produced: exactly (W-2)*(H-2) results per frame.
- EndOfFrame: tagged at stage 1 when the accepted pixel is (H-1, W-1). It travels with valid and is never high without ValidOut.
- Reset mid-frame: in-flight results are discarded. The next frame starts at (0,0). The line delays are not cleared, so the first 2 rows are masked anyway.
- DataOut holds its last value while ValidOut=0.

Optional Feature:
- SOBEL_THRESHOLD_EN defined: stage 3 outputs DataOut = (mag >= THRESHOLD) ? 255 : 0. Compared on the unsaturated 12-bit mag. Latency is unchanged.
- Not defined: saturated magnitude output; the THRESHOLD parameter is ignored.

Decomposition:
- Package sobel_pkg:
  - PIXEL_W=8, GRAD_W=11, MAG_W=12.
  - typedefs pixel_t (8b unsigned), grad_t (11b signed), mag_t (12b unsigned).
  - constant PIX_MAX=255.
- One natural sub-module, sobel_kernel_1d:
  - Inputs: six pixels (three negative-side, three positive-side; middle weighted x2).
  - Output: one grad_t difference.
  - Instantiated twice (Gx, Gy).
- Counters, window and pipeline stay in the top.

Test Plan:
- Flat frame, W=8, H=4, all pixels 100, Enable=1 continuously -> exactly 12 ValidOut pulses, all DataOut=0. First ValidOut 2 cycles after accepting (2,2). EndOfFrame only on the 12th.
- Horizontal ramp, pixel = column index, W=8, H=4 -> every output = 8 (Gx=8, Gy=0).
- Vertical step, W=256, H=4, pixel = 0 for col<128, else 200 -> windows centred at col 127 and 128 output 255 (Gx=800, saturated); all others 0. Count = 2*254.
- Flat frame with random Enable gaps (~40% low) -> same 12 results and order as the continuous case. No ValidOut except 2 cycles after a qualifying accept.
- Reset asserted mid-row-2 for one cycle -> ValidOut=0 from the next edge with no stale outputs. Restarted frame yields a full 12 results.
- SOBEL_THRESHOLD_EN, THRESHOLD=50: ramp frame -> all 0; vertical step -> 255 at cols 127/128, else 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared widths, pixel/gradient/magnitude types and helpers for the Sobel window core.
package sobel_pkg;

    localparam int PIXEL_W = 8;
    localparam int GRAD_W  = 11;
    localparam int MAG_W   = 12;

    typedef logic        [PIXEL_W-1:0] pixel_t;
    typedef logic signed [GRAD_W-1:0]  grad_t;
    typedef logic        [MAG_W-1:0]   mag_t;

    localparam pixel_t PIX_MAX = 8'd255;

    // |g| for g in [-1020, 1020]; negation cannot overflow in GRAD_W bits.
    function automatic mag_t abs_grad(input grad_t g);
        grad_t a;
        a = g[GRAD_W-1] ? -g : g;
        return {1'b0, a};
    endfunction

endpackage

// File: rtl/sobel_kernel_1d.sv
// One Sobel 1-D difference: (pos0 + 2*pos1 + pos2) - (neg0 + 2*neg1 + neg2).
module sobel_kernel_1d
    import sobel_pkg::*;
(
    input  logic [PIXEL_W-1:0] neg0_i,
    input  logic [PIXEL_W-1:0] neg1_i,
    input  logic [PIXEL_W-1:0] neg2_i,
    input  logic [PIXEL_W-1:0] pos0_i,
    input  logic [PIXEL_W-1:0] pos1_i,
    input  logic [PIXEL_W-1:0] pos2_i,
    output logic [GRAD_W-1:0]  diff_o
);

    grad_t pos_sum;
    grad_t neg_sum;

    // Each weighted sum is at most 4*255 = 1020, which fits the signed range.
    assign pos_sum = $signed({3'b000, pos0_i}) + $signed({2'b00, pos1_i, 1'b0})
                   + $signed({3'b000, pos2_i});
    assign neg_sum = $signed({3'b000, neg0_i}) + $signed({2'b00, neg1_i, 1'b0})
                   + $signed({3'b000, neg2_i});
    assign diff_o  = pos_sum - neg_sum;

endmodule

// File: rtl/sobel_window_core.sv
// 3x3 Sobel window, gradient and magnitude pipeline (2-cycle latency, 1 pixel/clock).
// Define SOBEL_THRESHOLD_EN to emit binary 0/255 at THRESHOLD instead of the saturated magnitude.
module sobel_window_core
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int THRESHOLD  = 64
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Enable,
    input  logic [7:0] DataIn,
    input  logic [7:0] Line1In,
    input  logic [7:0] Line2In,
    output logic [7:0] DataOut,
    output logic       ValidOut,
    output logic       EndOfFrame
);

    localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
    localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    pixel_t           win_q [3][3];   // [row][col], row 0 oldest line, col 2 newest pixel

    logic   s1_valid_q, s1_eof_q;
    logic   s2_valid_q, s2_eof_q;
    grad_t  gx_q, gy_q;
    grad_t  gx_c, gy_c;
    pixel_t data_q;
    logic   valid_q, eof_q;

    logic   win_ok, last_pix;
    mag_t   mag;
    pixel_t out_pix;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (Enable) begin
            if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Windows still straddling the row wrap or the first two rows are masked here.
    assign win_ok   = Enable && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign last_pix = Enable && (row_q == ROW_W'(IMG_HEIGHT - 1))
                             && (col_q == COL_W'(IMG_WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            col_q      <= '0;
            row_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_eof_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s1_valid_q <= win_ok;
            s1_eof_q   <= last_pix;
            if (Enable) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= Line2In;
                win_q[1][2] <= Line1In;
                win_q[2][2] <= DataIn;
            end
        end
    end

    sobel_kernel_1d u_gx (
        .neg0_i (win_q[0][0]),
        .neg1_i (win_q[1][0]),
        .neg2_i (win_q[2][0]),
        .pos0_i (win_q[0][2]),
        .pos1_i (win_q[1][2]),
        .pos2_i (win_q[2][2]),
        .diff_o (gx_c)
    );

    sobel_kernel_1d u_gy (
        .neg0_i (win_q[0][0]),
        .neg1_i (win_q[0][1]),
        .neg2_i (win_q[0][2]),
        .pos0_i (win_q[2][0]),
        .pos1_i (win_q[2][1]),
        .pos2_i (win_q[2][2]),
        .diff_o (gy_c)
    );

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            gx_q       <= '0;
            gy_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_eof_q   <= 1'b0;
        end else begin
            gx_q       <= gx_c;
            gy_q       <= gy_c;
            s2_valid_q <= s1_valid_q;
            s2_eof_q   <= s1_eof_q;
        end
    end

    assign mag = abs_grad(gx_q) + abs_grad(gy_q);

`ifdef SOBEL_THRESHOLD_EN
    assign out_pix = (mag >= MAG_W'(THRESHOLD)) ? PIX_MAX : '0;
`else
    assign out_pix = (mag > MAG_W'(PIX_MAX)) ? PIX_MAX : mag[PIXEL_W-1:0];
`endif

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            valid_q <= s2_valid_q;
            eof_q   <= s2_valid_q && s2_eof_q;
            if (s2_valid_q) begin
                data_q <= out_pix;
            end
        end
    end

    assign DataOut    = data_q;
    assign ValidOut   = valid_q;
    assign EndOfFrame = eof_q;

endmodule
